// File: rtl/recv_image.sv
// recv_image: receives one UDP video line per Ethernet frame, buffers its RGB words and writes them to DRAM as two AXI bursts
// Ports: eth_rxck/rst_rx clock and async active-high reset; rx_i {valid,byte} stream;
//        my_MACadd_i/my_IPadd_i/my_Port_i local addresses; frames_per_image_i lines per image (0 means 1);
//        axi_aw*/axi_w*/axi_b* AXI4 write master; frame_cnt_o line index; image_done_o end-of-image pulse;
//        drop_cnt_o saturating dropped-frame count; axi_err_o sticky write-response error.
module recv_image #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int MSG_SIZE = 1440,
  parameter int BURST_LEN = 240
) (
  input  logic        eth_rxck,
  input  logic        rst_rx,
  input  logic [8:0]  rx_i,
  input  logic [47:0] my_MACadd_i,
  input  logic [31:0] my_IPadd_i,
  input  logic [15:0] my_Port_i,
  input  logic [10:0] frames_per_image_i,
  output logic [31:0] axi_awaddr,
  output logic [7:0]  axi_awlen,
  output logic [2:0]  axi_awsize,
  output logic [1:0]  axi_awburst,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wlast,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [10:0] frame_cnt_o,
  output logic        image_done_o,
  output logic [15:0] drop_cnt_o,
  output logic        axi_err_o
);
  localparam int WORDS = MSG_SIZE / 3;
  localparam int IW = $clog2(WORDS);
  localparam logic [10:0] LAST = 11'(42 + MSG_SIZE - 1);
  localparam logic [15:0] UDP_LEN = 16'(MSG_SIZE + 8);
  typedef enum logic [2:0] {IDLE, HEAD, PAYLD, AW, W, B, SKIP} state_t;
  state_t r_state, w_next;
  logic r_prev_v, r_mine, r_bc, r_burst;
  logic [10:0] r_cnt;
  logic [1:0] r_ph;
  logic [7:0] r_b, r_g, r_beat;
  logic [IW-1:0] r_widx;
  logic [31:0] r_buf [WORDS];
  logic w_v, w_start, w_mine, w_bc, w_bad, w_drop, w_fin, w_wrap;
  logic [7:0] w_d, w_macb, w_ipb;
  logic [10:0] w_idx, w_fpi, w_frame_inc;
  logic [IW-1:0] w_ridx;
  assign w_v = rx_i[8];
  assign w_d = rx_i[7:0];
  // r_prev_v resets high so a frame already running at reset release is never taken as a start
  assign w_start = w_v && !r_prev_v;
  assign w_idx = (r_state == IDLE) ? 11'd0 : r_cnt;
  assign w_macb = 8'(my_MACadd_i >> {3'd5 - w_idx[2:0], 3'b000});
  assign w_ipb = 8'(my_IPadd_i >> {2'd1 - w_idx[1:0], 3'b000});
  // destination MAC may match either our address or broadcast, tracked as two running matches
  assign w_mine = (w_idx == 11'd0 || r_mine) && w_d == w_macb;
  assign w_bc = (w_idx == 11'd0 || r_bc) && w_d == 8'hFF;
  assign w_bad = (w_idx < 11'd6) ? !(w_mine || w_bc) :
                 (w_idx == 11'd12) ? w_d != 8'h08 :
                 (w_idx == 11'd13) ? w_d != 8'h00 :
                 (w_idx == 11'd14) ? w_d != 8'h45 :
                 (w_idx == 11'd23) ? w_d != 8'h11 :
                 (w_idx >= 11'd30 && w_idx <= 11'd33) ? w_d != w_ipb :
                 (w_idx == 11'd36) ? w_d != my_Port_i[15:8] :
                 (w_idx == 11'd37) ? w_d != my_Port_i[7:0] :
                 (w_idx == 11'd38) ? w_d != UDP_LEN[15:8] :
                 (w_idx == 11'd39) && w_d != UDP_LEN[7:0];
  assign w_fpi = (frames_per_image_i == 11'd0) ? 11'd1 : frames_per_image_i;
  assign w_frame_inc = frame_cnt_o + 11'd1;
  assign w_wrap = w_frame_inc == w_fpi;
  assign w_ridx = IW'(r_burst ? BURST_LEN : 0) + IW'(r_beat);
  assign axi_awaddr = BASE_ADDR + 32'(frame_cnt_o) * 32'(BURST_LEN * 8) + (r_burst ? 32'(BURST_LEN * 4) : 32'd0);
  assign axi_awlen = 8'(BURST_LEN - 1);
  assign axi_awsize = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awvalid = r_state == AW;
  assign axi_wvalid = r_state == W;
  assign axi_bready = r_state == B;
  assign axi_wdata = r_buf[w_ridx];
  assign axi_wstrb = 4'hF;
  assign axi_wlast = r_beat == 8'(BURST_LEN - 1);
  always_comb begin
    w_next = r_state;
    w_drop = 1'b0;
    w_fin = 1'b0;
    case (r_state)
      IDLE: if (w_start) begin
        w_next = w_bad ? SKIP : HEAD;
        w_drop = w_bad;
      end
      HEAD: if (!w_v || w_bad) begin
        w_next = w_v ? SKIP : IDLE;
        w_drop = 1'b1;
      end else if (r_cnt == 11'd41) w_next = PAYLD;
      PAYLD: if (!w_v) begin
        w_next = IDLE;
        w_drop = 1'b1;
      end else if (r_cnt == LAST) w_next = AW;
      AW: begin
        w_drop = w_start;
        if (axi_awready) w_next = W;
      end
      W: begin
        w_drop = w_start;
        if (axi_wready && axi_wlast) w_next = B;
      end
      B: begin
        w_drop = w_start;
        if (axi_bvalid) begin
          w_fin = r_burst;
          w_next = !r_burst ? AW : w_v ? SKIP : IDLE;
        end
      end
      SKIP: if (!w_v) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge eth_rxck or posedge rst_rx) begin
    if (rst_rx) begin
      r_state <= IDLE;
      r_prev_v <= 1'b1;
      r_mine <= 1'b0;
      r_bc <= 1'b0;
      r_burst <= 1'b0;
      r_cnt <= 11'd0;
      r_ph <= 2'd0;
      r_b <= 8'd0;
      r_g <= 8'd0;
      r_beat <= 8'd0;
      r_widx <= '0;
      frame_cnt_o <= 11'd0;
      image_done_o <= 1'b0;
      drop_cnt_o <= 16'd0;
      axi_err_o <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prev_v <= w_v;
      image_done_o <= w_fin && w_wrap;
      if (w_drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      if (w_idx < 11'd6) begin
        r_mine <= w_mine;
        r_bc <= w_bc;
      end
      if (r_state == IDLE && w_start) begin
        r_cnt <= 11'd1;
        r_ph <= 2'd0;
        r_widx <= '0;
      end else if (r_state == HEAD || r_state == PAYLD) r_cnt <= r_cnt + 11'd1;
      if (r_state == PAYLD && w_v) begin
        r_ph <= (r_ph == 2'd2) ? 2'd0 : r_ph + 2'd1;
        r_b <= (r_ph == 2'd0) ? w_d : r_b;
        r_g <= (r_ph == 2'd1) ? w_d : r_g;
        if (r_ph == 2'd2) r_widx <= r_widx + IW'(1);
      end
      if (r_state == PAYLD) r_burst <= 1'b0;
      if (r_state == AW) r_beat <= 8'd0;
      else if (r_state == W && axi_wready) r_beat <= r_beat + 8'd1;
      if (r_state == B && axi_bvalid) begin
        r_burst <= 1'b1;
        if (axi_bresp != 2'b00) axi_err_o <= 1'b1;
      end
      if (w_fin) frame_cnt_o <= w_wrap ? 11'd0 : w_frame_inc;
    end
  end
  always_ff @(posedge eth_rxck) if (r_state == PAYLD && w_v && r_ph == 2'd2) r_buf[r_widx] <= {8'h00, w_d, r_g, r_b};
endmodule

// File: tb/tb_recv_image.sv
// tb_recv_image: directed bench for recv_image with an AXI write slave model and payload scoreboard
module tb_recv_image;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;
  localparam logic [31:0] IP = 32'hC0A8_0102;
  localparam logic [15:0] PORT = 16'd5000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [8:0] rx_i = 9'h000;
  logic [10:0] fpi = 11'd4;
  logic [31:0] axi_awaddr, axi_wdata;
  logic [7:0] axi_awlen;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst;
  logic axi_awvalid, axi_wvalid, axi_wlast, axi_bready;
  logic [3:0] axi_wstrb;
  logic axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
  logic [1:0] axi_bresp = 2'b00;
  logic [10:0] frame_cnt;
  logic image_done, axi_err;
  logic [15:0] drop_cnt;
  int tests = 0, fails = 0;
  logic [31:0] aw_q[$];
  logic [12:0] attr_q[$];
  logic [31:0] w_q[$];
  logic last_q[$];
  int bcnt = 0, done_cnt = 0, stalls = 0, stab_err = 0, strb_err = 0;
  bit rnd = 0, err_b1 = 0, stall_prev = 0;
  logic [31:0] hold = 32'd0;
  always #5 clk = ~clk;
  recv_image #(.BASE_ADDR(BASE)) dut (
    .eth_rxck(clk), .rst_rx(rst), .rx_i(rx_i),
    .my_MACadd_i(MAC), .my_IPadd_i(IP), .my_Port_i(PORT), .frames_per_image_i(fpi),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .frame_cnt_o(frame_cnt), .image_done_o(image_done), .drop_cnt_o(drop_cnt), .axi_err_o(axi_err)
  );
  // slave model: readies change on the falling edge, so a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      axi_awready = 1'b0;
      axi_wready = 1'b0;
      axi_bvalid = 1'b0;
      stall_prev = 0;
    end else begin
      if (stall_prev && axi_wvalid && axi_wdata !== hold) stab_err++;
      axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi_bvalid = axi_bready;
      axi_bresp = (err_b1 && aw_q.size() > 0 && aw_q.size() % 2 == 0) ? 2'b10 : 2'b00;
      if (axi_awvalid && axi_awready) begin
        aw_q.push_back(axi_awaddr);
        attr_q.push_back({axi_awlen, axi_awsize, axi_awburst});
      end
      if (axi_wvalid && axi_wready) begin
        w_q.push_back(axi_wdata);
        last_q.push_back(axi_wlast);
        if (axi_wstrb !== 4'hF) strb_err++;
      end
      if (axi_bvalid) bcnt++;
      if (axi_wvalid && !axi_wready) stalls++;
      stall_prev = axi_wvalid && !axi_wready;
      hold = axi_wdata;
      if (image_done) done_cnt++;
    end
  end
  function automatic logic [7:0] pb(int seed, int j);
    return (seed == 0) ? 8'(j % 3) : 8'(j * 7 + seed);
  endfunction
  function automatic logic [31:0] wexp(int seed, int k);
    return {8'h00, pb(seed, 3 * k + 2), pb(seed, 3 * k + 1), pb(seed, 3 * k)};
  endfunction
  function automatic logic [7:0] fbyte(int i, logic [47:0] mac, logic [15:0] port, int seed);
    if (i < 6) return 8'(mac >> (8 * (5 - i)));
    if (i == 12) return 8'h08;
    if (i == 13) return 8'h00;
    if (i == 14) return 8'h45;
    if (i == 23) return 8'h11;
    if (i >= 30 && i < 34) return 8'(IP >> (8 * (33 - i)));
    if (i == 36) return port[15:8];
    if (i == 37) return port[7:0];
    if (i == 38) return 8'h05;
    if (i == 39) return 8'hA8;
    if (i < 42) return 8'h5A;
    if (i < 1482) return pb(seed, i - 42);
    return 8'hAA;
  endfunction
  function automatic int bad_words(int seed, int first);
    int b = 0;
    for (int k = 0; k < 480; k++) if (first + k >= w_q.size() || w_q[first + k] !== wexp(seed, k)) b++;
    return b;
  endfunction
  task automatic clr();
    aw_q.delete();
    attr_q.delete();
    w_q.delete();
    last_q.delete();
    bcnt = 0;
    done_cnt = 0;
    stalls = 0;
    stab_err = 0;
    strb_err = 0;
  endtask
  task automatic start(input logic [10:0] fp);
    fpi = fp;
    rnd = 0;
    err_b1 = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (2) @(negedge clk);
  endtask
  task automatic send_frame(input logic [47:0] mac, input logic [15:0] port, input int nbytes, input int seed);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      rx_i = {1'b1, fbyte(i, mac, port, seed)};
    end
    @(negedge clk);
    rx_i = 9'h000;
  endtask
  task automatic wait_b(input int n);
    for (int c = 0; c < 4000 && bcnt < n; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    tests++;
    if (bcnt < n) begin fails++; $display("FAIL wait_bresp: got %0d responses, need %0d", bcnt, n); end
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({axi_awvalid, axi_wvalid, axi_bready, image_done, axi_err} !== 5'b0) begin fails++; $display("FAIL reset_ctl: got %b expected 00000", {axi_awvalid, axi_wvalid, axi_bready, image_done, axi_err}); end
    tests++;
    if (frame_cnt !== 11'd0) begin fails++; $display("FAIL reset_frame: got %0d expected 0", frame_cnt); end
    tests++;
    if (drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    tests++;
    if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b0) begin fails++; $display("FAIL reset_release: got %b expected 000", {axi_awvalid, axi_wvalid, axi_bready}); end
  endtask
  task automatic test_single();
    int nl = 0;
    start(11'd4);
    send_frame(MAC, PORT, 1486, 0);
    wait_b(2);
    foreach (last_q[k]) nl += int'(last_q[k]);
    tests++;
    if (aw_q.size() != 2) begin fails++; $display("FAIL single_awcount: got %0d expected 2", aw_q.size()); end
    tests++;
    if (aw_q[0] !== BASE) begin fails++; $display("FAIL single_aw0: got %h expected %h", aw_q[0], BASE); end
    tests++;
    if (aw_q[1] !== BASE + 32'd960) begin fails++; $display("FAIL single_aw1: got %h expected %h", aw_q[1], BASE + 32'd960); end
    tests++;
    if (attr_q[0] !== {8'd239, 3'b010, 2'b01}) begin fails++; $display("FAIL single_awattr: got %h expected %h", attr_q[0], {8'd239, 3'b010, 2'b01}); end
    tests++;
    if (w_q.size() != 480) begin fails++; $display("FAIL single_beats: got %0d expected 480", w_q.size()); end
    tests++;
    if (w_q[0] !== 32'h0002_0100) begin fails++; $display("FAIL single_first: got %h expected 00020100", w_q[0]); end
    tests++;
    if (bad_words(0, 0) != 0) begin fails++; $display("FAIL single_data: got %0d bad words expected 0", bad_words(0, 0)); end
    tests++;
    if (nl != 2 || last_q[239] !== 1'b1 || last_q[479] !== 1'b1) begin fails++; $display("FAIL single_wlast: got %0d lasts expected 2 at beats 239/479", nl); end
    tests++;
    if (strb_err != 0) begin fails++; $display("FAIL single_wstrb: got %0d bad strobes expected 0", strb_err); end
    tests++;
    if (frame_cnt !== 11'd1 || drop_cnt !== 16'd0 || axi_err !== 1'b0) begin fails++; $display("FAIL single_status: got frame %0d drop %0d err %b expected 1 0 0", frame_cnt, drop_cnt, axi_err); end
  endtask
  task automatic test_drops();
    start(11'd4);
    send_frame(MAC, PORT + 16'd1, 1486, 0);
    repeat (4) @(negedge clk);
    send_frame(MAC, PORT, 800, 0);
    repeat (600) @(negedge clk);
    tests++;
    if (aw_q.size() != 0) begin fails++; $display("FAIL drops_noaw: got %0d bursts expected 0", aw_q.size()); end
    tests++;
    if (drop_cnt !== 16'd2) begin fails++; $display("FAIL drops_cnt: got %0d expected 2", drop_cnt); end
    send_frame(48'h02_11_22_33_44_56, PORT, 1486, 0);
    repeat (600) @(negedge clk);
    tests++;
    if (drop_cnt !== 16'd3 || aw_q.size() != 0) begin fails++; $display("FAIL drops_mac: got drop %0d bursts %0d expected 3 0", drop_cnt, aw_q.size()); end
    send_frame(48'hFFFF_FFFF_FFFF, PORT, 1486, 4);
    wait_b(2);
    tests++;
    if (aw_q.size() != 2 || frame_cnt !== 11'd1 || drop_cnt !== 16'd3) begin fails++; $display("FAIL drops_bcast: got bursts %0d frame %0d drop %0d expected 2 1 3", aw_q.size(), frame_cnt, drop_cnt); end
    tests++;
    if (bad_words(4, 0) != 0) begin fails++; $display("FAIL drops_bcast_data: got %0d bad words expected 0", bad_words(4, 0)); end
  endtask
  task automatic test_image();
    start(11'd3);
    for (int f = 0; f < 3; f++) begin
      send_frame(MAC, PORT, 1486, f + 1);
      wait_b(2 * (f + 1));
      tests++;
      if (frame_cnt !== ((f == 2) ? 11'd0 : 11'(f + 1)) || done_cnt != ((f == 2) ? 1 : 0)) begin fails++; $display("FAIL image_frame%0d: got cnt %0d done %0d expected %0d %0d", f, frame_cnt, done_cnt, (f == 2) ? 0 : f + 1, (f == 2) ? 1 : 0); end
    end
    tests++;
    if (aw_q[4] !== BASE + 32'd3840 || aw_q[5] !== BASE + 32'd4800) begin fails++; $display("FAIL image_aw3: got %h %h expected %h %h", aw_q[4], aw_q[5], BASE + 32'd3840, BASE + 32'd4800); end
    tests++;
    if (bad_words(3, 960) != 0) begin fails++; $display("FAIL image_data3: got %0d bad words expected 0", bad_words(3, 960)); end
    start(11'd0);
    send_frame(MAC, PORT, 1486, 8);
    wait_b(2);
    tests++;
    if (frame_cnt !== 11'd0 || done_cnt != 1 || aw_q[0] !== BASE) begin fails++; $display("FAIL image_fpi0: got cnt %0d done %0d aw %h expected 0 1 %h", frame_cnt, done_cnt, aw_q[0], BASE); end
  endtask
  task automatic test_stall();
    start(11'd4);
    rnd = 1;
    err_b1 = 1;
    send_frame(MAC, PORT, 1486, 9);
    wait_b(2);
    rnd = 0;
    err_b1 = 0;
    tests++;
    if (stalls == 0 || stab_err != 0) begin fails++; $display("FAIL stall_stable: got %0d stalls %0d changes expected >0 and 0", stalls, stab_err); end
    tests++;
    if (w_q.size() != 480 || bad_words(9, 0) != 0) begin fails++; $display("FAIL stall_data: got %0d beats %0d bad expected 480 0", w_q.size(), bad_words(9, 0)); end
    tests++;
    if (axi_err !== 1'b1 || frame_cnt !== 11'd1) begin fails++; $display("FAIL stall_err: got err %b frame %0d expected 1 1", axi_err, frame_cnt); end
    tests++;
    if (aw_q[1] !== BASE + 32'd960) begin fails++; $display("FAIL stall_aw1: got %h expected %h", aw_q[1], BASE + 32'd960); end
  endtask
  task automatic test_back_to_back();
    start(11'd4);
    send_frame(MAC, PORT, 1486, 1);
    send_frame(MAC, PORT, 1486, 2);
    wait_b(2);
    repeat (10) @(negedge clk);
    tests++;
    if (drop_cnt !== 16'd1) begin fails++; $display("FAIL b2b_drop: got %0d expected 1", drop_cnt); end
    tests++;
    if (aw_q.size() != 2 || w_q.size() != 480) begin fails++; $display("FAIL b2b_count: got %0d bursts %0d beats expected 2 480", aw_q.size(), w_q.size()); end
    tests++;
    if (bad_words(1, 0) != 0) begin fails++; $display("FAIL b2b_data: got %0d bad words expected 0", bad_words(1, 0)); end
    tests++;
    if (frame_cnt !== 11'd1) begin fails++; $display("FAIL b2b_frame: got %0d expected 1", frame_cnt); end
  endtask
  task automatic test_reset_mid();
    start(11'd4);
    send_frame(MAC, PORT + 16'd1, 1486, 0);
    send_frame(MAC, PORT, 1486, 3);
    wait_b(2);
    send_frame(MAC, PORT, 1486, 5);
    for (int c = 0; c < 1000 && w_q.size() < 530; c++) @(negedge clk);
    tests++;
    if (axi_wvalid !== 1'b1) begin fails++; $display("FAIL rmid_inburst: got wvalid %b expected 1", axi_wvalid); end
    rst = 1'b1;
    #1;
    tests++;
    if ({axi_awvalid, axi_wvalid, axi_bready, image_done, axi_err} !== 5'b0 || axi_awaddr !== BASE) begin fails++; $display("FAIL rmid_ctl: got %b addr %h expected 00000 %h", {axi_awvalid, axi_wvalid, axi_bready, image_done, axi_err}, axi_awaddr, BASE); end
    tests++;
    if (frame_cnt !== 11'd0 || drop_cnt !== 16'd0) begin fails++; $display("FAIL rmid_cnt: got frame %0d drop %0d expected 0 0", frame_cnt, drop_cnt); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (300) @(negedge clk);
    tests++;
    if (aw_q.size() != 0 || w_q.size() != 0) begin fails++; $display("FAIL rmid_resume: got %0d bursts %0d beats expected 0 0", aw_q.size(), w_q.size()); end
    send_frame(MAC, PORT, 1486, 6);
    wait_b(2);
    tests++;
    if (aw_q[0] !== BASE || bad_words(6, 0) != 0 || frame_cnt !== 11'd1) begin fails++; $display("FAIL rmid_next: got aw %h bad %0d frame %0d expected %h 0 1", aw_q[0], bad_words(6, 0), frame_cnt, BASE); end
    clr();
    fork
      send_frame(MAC, PORT, 1486, 7);
      begin
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (600) @(negedge clk);
    tests++;
    if (aw_q.size() != 0 || drop_cnt !== 16'd0 || frame_cnt !== 11'd0) begin fails++; $display("FAIL rmid_inframe: got bursts %0d drop %0d frame %0d expected 0 0 0", aw_q.size(), drop_cnt, frame_cnt); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_drops();
    test_image();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/recv_image.md
RECV_IMAGE -- requirements
Module: recv_image

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: DRAM byte address of image line 0.
REQ-002 SHALL have parameter MSG_SIZE, default 1440: UDP payload bytes per frame (480 pixels).
REQ-003 SHALL have parameter BURST_LEN, default 240: AXI beats per write burst (2 bursts per frame).
REQ-004 eth_rxck  in  1  sole clock; rst_rx  in  1  reset, asynchronous, active-high.
REQ-005 rx_i  in  9  [8]=frame valid (high for whole frame, preamble/SFD stripped), [7:0]=byte.
REQ-006 my_MACadd_i in 48, my_IPadd_i in 32, my_Port_i in 16: local addresses to match.
REQ-007 frames_per_image_i  in  11  frames per image; 0 is treated as 1.
REQ-008 axi_awaddr out 32, axi_awlen out 8, axi_awsize out 3, axi_awburst out 2, axi_awvalid out 1, axi_awready in 1.
REQ-009 axi_wdata out 32, axi_wstrb out 4, axi_wlast out 1, axi_wvalid out 1, axi_wready in 1.
REQ-010 axi_bresp in 2, axi_bvalid in 1, axi_bready out 1.
REQ-011 frame_cnt_o out 11 (current line index), image_done_o out 1 (pulse), drop_cnt_o out 16, axi_err_o out 1 (sticky).

Function
REQ-012 Frame start = rising edge of rx_i[8]; byte index 0 is the first byte with rx_i[8]=1; 11-bit byte counter.
REQ-013 States: IDLE, HEAD (bytes 0-41), PAYLD (bytes 42-1481), AW, W, B, SKIP (wait for rx_i[8]=0).
REQ-014 HEAD checks: dst MAC == my_MACadd_i or FF..FF; bytes 12-13 = 16'h0800; byte 14 = 8'h45; byte 23 = 8'h11; bytes 30-33 == my_IPadd_i; bytes 36-37 == my_Port_i; bytes 38-39 == MSG_SIZE+8.
REQ-015 Any failed check: go to SKIP at once, drop_cnt_o +1 (saturating at 16'hFFFF); IP/UDP checksums not checked.
REQ-016 PAYLD packs byte triplets B,G,R (in arrival order) into word {8'h00,R,G,B}; words stored at index 0..479 of a 480x32 buffer.
REQ-017 rx_i[8] falling before byte 1481 (runt): drop, drop_cnt_o +1, return to IDLE, no AXI activity.
REQ-018 Cycle after byte 1481 captured: enter AW; bytes after 1481 (FCS/dummy) ignored.
REQ-019 Burst n (n=0,1): awaddr = BASE_ADDR + frame_cnt_o*1920 + n*960; awlen=BURST_LEN-1; awsize=3'b010; awburst=2'b01.
REQ-020 AW: awvalid held until awready; then W: beats words n*240..n*240+239, wstrb 4'hF, wlast on beat 239, data stable while wvalid&&!wready.
REQ-021 B: bready=1 until bvalid; bresp!=2'b00 sets axi_err_o (cleared only by reset); after burst 0 go to AW for burst 1.
REQ-022 After burst 1 response: frame_cnt_o +1; if new value == frames_per_image_i, frame_cnt_o <= 0 and image_done_o high 1 cycle.
REQ-023 Then go to SKIP if rx_i[8]=1, else IDLE.
REQ-024 Frame start seen during AW/W/B: that frame dropped, drop_cnt_o +1 once; buffer untouched.
REQ-025 SKIP exits to IDLE on rx_i[8]=0; a start requires rx_i[8] low at least 1 cycle.
REQ-026 No combinational path from AXI ready inputs to valid outputs.

Reset
REQ-027 rst_rx=1 asynchronously: state IDLE, all valids and bready 0, frame_cnt_o 0, drop_cnt_o 0, image_done_o 0, axi_err_o 0.
REQ-028 Reset mid-burst aborts the transfer; no resumption after release.
REQ-029 After release, a frame already in progress (rx_i[8]=1) is ignored until rx_i[8] goes low.

Verification
REQ-030 Valid frame to my MAC/IP/port, payload bytes 00,01,02 repeating, ready always 1 -> bursts at BASE_ADDR and BASE_ADDR+960, first wdata 32'h0002_0100, 480 beats total, frame_cnt_o=1.
REQ-031 Wrong dst port, then runt (valid drops at byte 800) -> no awvalid, drop_cnt_o=2.
REQ-032 frames_per_image_i=3, three valid frames -> third frame's awaddr = BASE_ADDR+3840, image_done_o one pulse, frame_cnt_o=0.
REQ-033 Random awready/wready stalls plus bresp=2'b10 on burst 1 -> wdata held stable during stalls, axi_err_o=1, frame_cnt_o still increments.
REQ-034 Second frame starts while burst 0 in W -> drop_cnt_o=1, written data equals first frame only.
REQ-035 rst_rx pulsed mid W-burst -> all outputs at reset values same cycle; next valid frame writes from BASE_ADDR.
